// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared FSM states and AXI response codes; write states gated by AXI_LITE_MASTER_WRITE_EN
package axi_lite_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RADDR,
        RDATA
`ifdef AXI_LITE_MASTER_WRITE_EN
        ,
        WREQ,
        WRESP
`endif
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_lite_master_if.sv
// rtl/axi_lite_master_if.sv - core request/response and AXI-lite channel bundle
interface axi_lite_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_wen;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_wstrb;
    logic                  rsp_valid;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;

    logic [ADDR_W-1:0]     araddr;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_W-1:0]     rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;
    logic [ADDR_W-1:0]     awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    modport master (
        input  req_valid, req_wen, req_addr, req_wdata, req_wstrb,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output araddr, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready,
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready
    );

    modport slave (
        output req_valid, req_wen, req_addr, req_wdata, req_wstrb,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready,
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready
    );

endinterface

// File: rtl/axi_lite_master.sv
// rtl/axi_lite_master.sv - single-outstanding AXI-lite master; write path enabled by AXI_LITE_MASTER_WRITE_EN
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    axi_lite_master_if.master   bus
);

    state_t                state, state_n;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W/8-1:0]   wstrb_q;
    logic                  rsp_valid_q, rsp_valid_n;
    logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_n;
    logic                  rsp_err_q, rsp_err_n;
    logic                  req_ready, arvalid, rready, awvalid, wvalid, bready;
    logic                  accept;

`ifdef AXI_LITE_MASTER_WRITE_EN
    logic                  aw_done, aw_done_n;
    logic                  w_done, w_done_n;
`else
    logic                  unused_write_inputs;
    assign unused_write_inputs = &{1'b0, bus.awready, bus.wready, bus.bresp, bus.bvalid};
`endif

    assign accept = req_ready && bus.req_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef AXI_LITE_MASTER_WRITE_EN
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            rsp_valid_q <= rsp_valid_n;
            rsp_rdata_q <= rsp_rdata_n;
            rsp_err_q   <= rsp_err_n;
`ifdef AXI_LITE_MASTER_WRITE_EN
            aw_done     <= aw_done_n;
            w_done      <= w_done_n;
`endif
            if (accept) begin
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                wstrb_q <= bus.req_wstrb;
            end
        end
    end

    always_comb begin
        state_n     = state;
        rsp_valid_n = 1'b0;
        rsp_rdata_n = rsp_rdata_q;
        rsp_err_n   = rsp_err_q;
        req_ready   = 1'b0;
        arvalid     = 1'b0;
        rready      = 1'b0;
        awvalid     = 1'b0;
        wvalid      = 1'b0;
        bready      = 1'b0;
`ifdef AXI_LITE_MASTER_WRITE_EN
        aw_done_n   = aw_done;
        w_done_n    = w_done;
`endif
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (!bus.req_wen) begin
                        state_n = RADDR;
                    end else begin
`ifdef AXI_LITE_MASTER_WRITE_EN
                        state_n   = WREQ;
                        aw_done_n = 1'b0;
                        w_done_n  = 1'b0;
`else
                        // No write path in this build: refuse immediately.
                        rsp_valid_n = 1'b1;
                        rsp_err_n   = 1'b1;
`endif
                    end
                end
            end
            RADDR: begin
                arvalid = 1'b1;
                if (bus.arready) state_n = RDATA;
            end
            RDATA: begin
                rready = 1'b1;
                if (bus.rvalid) begin
                    state_n     = IDLE;
                    rsp_valid_n = 1'b1;
                    rsp_rdata_n = bus.rdata;
                    rsp_err_n   = (bus.rresp != RESP_OKAY);
                end
            end
`ifdef AXI_LITE_MASTER_WRITE_EN
            WREQ: begin
                // Address and data channels complete independently, in any order.
                awvalid   = !aw_done;
                wvalid    = !w_done;
                aw_done_n = aw_done || bus.awready;
                w_done_n  = w_done || bus.wready;
                if (aw_done_n && w_done_n) begin
                    state_n   = WRESP;
                    aw_done_n = 1'b0;
                    w_done_n  = 1'b0;
                end
            end
            WRESP: begin
                bready = 1'b1;
                if (bus.bvalid) begin
                    state_n     = IDLE;
                    rsp_valid_n = 1'b1;
                    rsp_err_n   = (bus.bresp != RESP_OKAY);
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.araddr    = addr_q;
    assign bus.arvalid   = arvalid;
    assign bus.rready    = rready;
    assign bus.awaddr    = addr_q;
    assign bus.awvalid   = awvalid;
    assign bus.wdata     = wdata_q;
    assign bus.wstrb     = wstrb_q;
    assign bus.wvalid    = wvalid;
    assign bus.bready    = bready;

endmodule

// File: tb/tb_axi_lite_master.sv
// tb/tb_axi_lite_master.sv - randomized bench with a transaction-level model for axi_lite_master
module tb_axi_lite_master;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    logic [63:0] last_rdata = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axi_lite_master_if #(.ADDR_W(32), .DATA_W(64)) bus ();

    axi_lite_master #(.ADDR_W(32), .DATA_W(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 16) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic do_read(input logic [31:0] a, input logic [63:0] d, input logic [1:0] r,
                           input int ar_w, input int r_w);
        int acc;
        bus.req_valid = 1'b1;
        bus.req_wen   = 1'b0;
        bus.req_addr  = a;
        bus.req_wdata = {$urandom, $urandom};
        check("rd_req_ready", bus.req_ready, 1);
        acc = cyc;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom;
        for (int i = 0; i < ar_w; i++) begin
            check("rd_arvalid_wait", bus.arvalid, 1);
            check("rd_araddr_wait", bus.araddr, a);
            check("rd_req_ready_busy", bus.req_ready, 0);
            @(negedge clk);
        end
        check("rd_arvalid", bus.arvalid, 1);
        check("rd_araddr", bus.araddr, a);
        bus.arready = 1'b1;
        @(negedge clk);
        bus.arready = 1'b0;
        check("rd_arvalid_drop", bus.arvalid, 0);
        for (int i = 0; i < r_w; i++) begin
            check("rd_rready_wait", bus.rready, 1);
            check("rd_rsp_early", bus.rsp_valid, 0);
            bus.rdata = {$urandom, $urandom};
            @(negedge clk);
        end
        check("rd_rready", bus.rready, 1);
        bus.rvalid = 1'b1;
        bus.rdata  = d;
        bus.rresp  = r;
        @(negedge clk);
        bus.rvalid = 1'b0;
        bus.rdata  = {$urandom, $urandom};
        wait_rsp();
        check("rd_latency", cyc - acc, 3 + ar_w + r_w);
        check("rd_rsp_valid", bus.rsp_valid, 1);
        check("rd_rsp_rdata", bus.rsp_rdata, d);
        check("rd_rsp_err", bus.rsp_err, (r != 2'b00));
        check("rd_rready_idle", bus.rready, 0);
        last_rdata = d;
        @(negedge clk);
        check("rd_rsp_pulse", bus.rsp_valid, 0);
        check("rd_rdata_hold", bus.rsp_rdata, d);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                            input int aw_w, input int w_w, input int b_w, input logic [1:0] br);
        int acc;
`ifdef AXI_LITE_MASTER_WRITE_EN
        int n;
`endif
        bus.req_valid = 1'b1;
        bus.req_wen   = 1'b1;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_wstrb = s;
        check("wr_req_ready", bus.req_ready, 1);
        acc = cyc;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_wen   = 1'b0;
        bus.req_addr  = $urandom;
        bus.req_wdata = {$urandom, $urandom};
`ifdef AXI_LITE_MASTER_WRITE_EN
        n = (aw_w > w_w) ? aw_w : w_w;
        for (int k = 0; k <= n; k++) begin
            check("wr_awvalid", bus.awvalid, (k <= aw_w));
            check("wr_wvalid", bus.wvalid, (k <= w_w));
            check("wr_awaddr", bus.awaddr, a);
            check("wr_wdata", bus.wdata, d);
            check("wr_wstrb", bus.wstrb, s);
            check("wr_req_ready_busy", bus.req_ready, 0);
            bus.awready = (k == aw_w);
            bus.wready  = (k == w_w);
            @(negedge clk);
        end
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        for (int i = 0; i < b_w; i++) begin
            check("wr_bready_wait", bus.bready, 1);
            check("wr_aw_idle", bus.awvalid, 0);
            check("wr_w_idle", bus.wvalid, 0);
            @(negedge clk);
        end
        check("wr_bready", bus.bready, 1);
        bus.bvalid = 1'b1;
        bus.bresp  = br;
        @(negedge clk);
        bus.bvalid = 1'b0;
        wait_rsp();
        check("wr_latency", cyc - acc, 3 + n + b_w);
        check("wr_rsp_valid", bus.rsp_valid, 1);
        check("wr_rsp_err", bus.rsp_err, (br != 2'b00));
        check("wr_rdata_keep", bus.rsp_rdata, last_rdata);
        check("wr_bready_idle", bus.bready, 0);
`else
        check("wr_off_latency", cyc - acc, 1);
        check("wr_off_rsp_valid", bus.rsp_valid, 1);
        check("wr_off_rsp_err", bus.rsp_err, 1);
        check("wr_off_awvalid", bus.awvalid, 0);
        check("wr_off_wvalid", bus.wvalid, 0);
        check("wr_off_bready", bus.bready, 0);
        check("wr_off_req_ready", bus.req_ready, 1);
        if (aw_w + w_w + b_w < 0) check("wr_off_unused", br, 0);
`endif
        @(negedge clk);
        check("wr_rsp_pulse", bus.rsp_valid, 0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [63:0] rd;
        logic [1:0]  rr;
        logic [7:0]  rs;

        bus.req_valid = 1'b0;
        bus.req_wen   = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_wstrb = '0;
        bus.arready   = 1'b0;
        bus.rdata     = '0;
        bus.rresp     = 2'b00;
        bus.rvalid    = 1'b0;
        bus.awready   = 1'b0;
        bus.wready    = 1'b0;
        bus.bresp     = 2'b00;
        bus.bvalid    = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_arvalid", bus.arvalid, 0);
        check("rst_rready", bus.rready, 0);
        check("rst_awvalid", bus.awvalid, 0);
        check("rst_wvalid", bus.wvalid, 0);
        check("rst_bready", bus.bready, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_rdata", bus.rsp_rdata, 0);
        check("rst_rsp_err", bus.rsp_err, 0);
        check("rst_araddr", bus.araddr, 0);
        rst = 1'b0;
        @(negedge clk);

        do_read(32'h8000_0000, 64'h1122_3344_5566_7788, 2'b00, 0, 0);
        do_read(32'h8000_0000, {$urandom, $urandom}, 2'b00, 4, 0);
        do_read(32'h8000_0008, {$urandom, $urandom}, 2'b10, 0, 1);
        do_write(32'h8000_0010, 64'h0000_0000_DEAD_BEEF, 8'h0F, 2, 0, 0, 2'b00);
        do_write(32'h8000_0018, {$urandom, $urandom}, 8'hF0, 0, 3, 1, 2'b10);

        // Stray responses while idle must not produce a completion.
        bus.rvalid = 1'b1;
        bus.bvalid = 1'b1;
        bus.rdata  = {$urandom, $urandom};
        repeat (2) begin
            @(negedge clk);
            check("stray_rsp_valid", bus.rsp_valid, 0);
            check("stray_rdata_hold", bus.rsp_rdata, last_rdata);
        end
        bus.rvalid = 1'b0;
        bus.bvalid = 1'b0;

        // Abort a read in RDATA with reset.
        bus.req_valid = 1'b1;
        bus.req_wen   = 1'b0;
        bus.req_addr  = 32'h8000_0020;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.arready   = 1'b1;
        @(negedge clk);
        bus.arready   = 1'b0;
        check("abort_in_rdata", bus.rready, 1);
        rst        = 1'b1;
        bus.rvalid = 1'b1;
        bus.rdata  = 64'hA5A5_A5A5_A5A5_A5A5;
        @(negedge clk);
        rst = 1'b0;
        last_rdata = '0;
        check("abort_rready", bus.rready, 0);
        check("abort_arvalid", bus.arvalid, 0);
        check("abort_rsp_valid", bus.rsp_valid, 0);
        check("abort_req_ready", bus.req_ready, 1);
        check("abort_rsp_rdata", bus.rsp_rdata, 0);
        check("abort_rsp_err", bus.rsp_err, 0);
        @(negedge clk);
        bus.rvalid = 1'b0;
        check("abort_no_rsp", bus.rsp_valid, 0);
        do_read(32'h8000_0028, 64'h0123_4567_89AB_CDEF, 2'b00, 0, 0);

        for (int t = 0; t < 24; t++) begin
            ra = $urandom;
            rd = {$urandom, $urandom};
            rr = 2'($urandom_range(0, 3));
            rs = 8'($urandom);
            if ($urandom_range(0, 1) == 0)
                do_read(ra, rd, rr, $urandom_range(0, 3), $urandom_range(0, 3));
            else
                do_write(ra, rd, rs, $urandom_range(0, 3), $urandom_range(0, 3),
                         $urandom_range(0, 3), rr);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
